// File: rtl/alu_seq_pkg.sv
// Shared opcode and handshake FSM state encodings for the alu_seq block.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_EQ      = 2'b01,
        OP_MUL     = 2'b10,
        OP_ILL_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, LSB first, full 2*WIDTH product.
// Latency: WIDTH cycles of busy after the start edge; done_o flags the final iteration.
// Backpressure: none; product_o holds its value until the next start.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               last;

    assign last = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d  = acc_q;
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            acc_d  = '0;
            a_sh_d = {{WIDTH{1'b0}}, a_i};
            b_sh_d = b_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Zero operands still run every iteration so latency is data-independent.
            if (b_sh_q[0]) begin
                acc_d = acc_q + a_sh_q;
            end
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = last;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked add/eq/mul ALU; opcode 11 subtracts when ALU_SEQ_SUB_EN is defined, else flags illegal.
// Latency: 1 cycle add/eq/opcode 11, WIDTH+1 cycles mul (accept edge to out_valid).
// Backpressure: result held in DONE until out_ready; in_ready low from accept until that handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal_operation
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     wide_sum;
`ifdef ALU_SEQ_SUB_EN
    logic [WIDTH:0]     wide_diff;
`endif

    assign accept   = in_valid && (state_q == ST_IDLE);
    assign wide_sum = {1'b0, a} + {1'b0, b};
`ifdef ALU_SEQ_SUB_EN
    // Top bit of the extended difference is the borrow, i.e. a < b.
    assign wide_diff = {1'b0, a} - {1'b0, b};
`endif

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        ill_d     = ill_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_e'(opcode);
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                    case (op_e'(opcode))
                        OP_ADD: begin
                            res_d = wide_sum[WIDTH-1:0];
                            ovf_d = wide_sum[WIDTH];
                        end
                        OP_EQ: begin
                            res_d = {{(WIDTH-1){1'b0}}, (a == b)};
                        end
                        OP_MUL: begin
                            mul_start = !mul_busy;
                            state_d   = ST_MUL;
                        end
                        default: begin
`ifdef ALU_SEQ_SUB_EN
                            res_d = wide_diff[WIDTH-1:0];
                            ovf_d = wide_diff[WIDTH];
`else
                            res_d = '1;
                            ill_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    // Multiply results are read straight from the multiplier, which holds its product until restarted.
    assign in_ready          = (state_q == ST_IDLE);
    assign out_valid         = (state_q == ST_DONE);
    assign result            = (op_q == OP_MUL) ? mul_product[WIDTH-1:0] : res_q;
    assign overflow          = (op_q == OP_MUL) ? |mul_product[2*WIDTH-1:WIDTH] : ovf_q;
    assign illegal_operation = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq against an arithmetic reference model (WIDTH=5).
module tb_alu_seq;

    localparam int W = 5;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         overflow;
    logic         illegal_operation;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .opcode           (opcode),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .overflow         (overflow),
        .illegal_operation(illegal_operation)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int op, input int av, input int bv,
                                  output int r, output int ov, output int il);
        int p;
        r = 0; ov = 0; il = 0;
        case (op)
            0: begin p = av + bv; r = p % M; ov = (p >= M) ? 1 : 0; end
            1: r = (av == bv) ? 1 : 0;
            2: begin p = av * bv; r = p % M; ov = (p >= M) ? 1 : 0; end
            default: begin
`ifdef ALU_SEQ_SUB_EN
                r  = (av - bv + M) % M;
                ov = (av < bv) ? 1 : 0;
`else
                r  = M - 1;
                il = 1;
`endif
            end
        endcase
    endfunction

    task automatic run_op(input int op, input int av, input int bv, input int hold);
        int er, eo, ei, n, lat;
        model(op, av, bv, er, eo, ei);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = W'(av);
        b         = W'(bv);
        opcode    = 2'(op);
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_pre", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, (op == 2) ? W + 1 : 1);
        for (int i = 0; i < hold; i++) begin
            check("hold_result", 32'(result), er);
            check("hold_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        check("out_valid", 32'(out_valid), 1);
        check("result", 32'(result), er);
        check("overflow", 32'(overflow), eo);
        check("illegal", 32'(illegal_operation), ei);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_post", 32'(out_valid), 0);
        check("in_ready_post", 32'(in_ready), 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_illegal", 32'(illegal_operation), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the block's reference scenarios.
        run_op(0, 20, 15, 0);
        run_op(2, 6, 5, 0);
        run_op(2, 7, 5, 1);
        run_op(2, 31, 0, 0);
        run_op(1, 9, 9, 0);
        run_op(1, 9, 8, 0);
        run_op(3, 3, 7, 0);
        run_op(0, 31, 31, 0);
        run_op(2, 31, 31, 2);

        // Backpressure with a new operation held on the input.
        @(negedge clk);
        in_valid = 1'b1; a = 5'd1; b = 5'd2; opcode = 2'd0; out_ready = 1'b0;
        @(negedge clk);
        a = 5'd5; b = 5'd6;
        check("bp_out_valid", 32'(out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            check("bp_result", 32'(result), 3);
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        check("bp_result_last", 32'(result), 3);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_out_valid_drop", 32'(out_valid), 0);
        check("bp_in_ready_back", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 1);
        check("bp_second_result", 32'(result), 11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; a = 5'd6; b = 5'd5; opcode = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_in_ready", 32'(in_ready), 1);
        check("mrst_no_stale", 32'(out_valid), 0);
        run_op(0, 4, 4, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
                   int'($urandom_range(0, M - 1)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
